// File: rtl/card_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// card_arbiter_pkg
// Shared definitions for the card_arbiter slice and the card_driver engine:
// FSM state encodings, block size and block-address width.
// Optional build macro honoured by this slice: CARD_ARB_FIXED_PRIO_EN
// (see card_rr_pick).
// ---------------------------------------------------------------------------
package card_arbiter_pkg;

  localparam int CARD_BLOCK_BYTES = 512;
  localparam int CARD_ADDR_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } card_state_e;

  // Turns a client index into its one-hot position on a 2-bit bus.
  function automatic logic [1:0] clientOneHot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/card_rr_pick.sv
// ---------------------------------------------------------------------------
// card_rr_pick
// Combinational grant picker for two requesters.
//   req  in  2  request vector
//   last in  1  index of the client served most recently
//   gnt  out 2  one-hot grant (all zero when nothing is requested)
// Build macro CARD_ARB_FIXED_PRIO_EN: when defined, client 0 always wins a
// tie and 'last' is ignored; otherwise the client that was not served last
// wins a tie.
// ---------------------------------------------------------------------------
module card_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

`ifdef CARD_ARB_FIXED_PRIO_EN
  // Fixed priority: client 0 first, client 1 only when client 0 is quiet.
  always_comb begin
    gnt = 2'b00;
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

  logic unusedLast;
  assign unusedLast = last;
`else
  // Round-robin: a lone request wins outright; on a tie the client that was
  // not served last is preferred.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end
`endif

endmodule

// File: rtl/card_arbiter.sv
// ---------------------------------------------------------------------------
// card_arbiter
// Shares one card_driver block-transfer engine between two clients. Whole
// block transactions are arbitrated one at a time; the winner's command is
// forwarded to the driver WR_* / RD_* channel and its byte stream is routed
// combinationally through WD_* (write) or RES_* (read).
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   C_REQ[1:0]               per-client request, held until its C_DONE
//   C_WE[1:0]                1 = block write, 0 = block read (sampled at grant)
//   C_ADDR[63:0]             client k block address in [32k+31:32k]
//   C_WD_STB/C_WD_DATA/C_WD_ACK    client write-byte streams
//   C_RES_STB/C_RES_DATA/C_RES_ACK client read-byte streams (data shared)
//   C_DONE[1:0]              one-cycle pulse at end of a transaction
//   BUSY                     high whenever the arbiter is not idle
//   WR_STB/WR_ADDR/WR_ACK    driver write command
//   RD_STB/RD_ADDR/RD_ACK    driver read command
//   WD_STB/WD_DATA/WD_ACK    driver write-byte stream
//   RES_STB/RES_DATA/RES_ACK driver read-byte stream
//
// Build macro CARD_ARB_FIXED_PRIO_EN selects fixed priority (client 0 wins
// ties) instead of round-robin; it is consumed by card_rr_pick.
// ---------------------------------------------------------------------------
module card_arbiter
  import card_arbiter_pkg::*;
#(
  parameter int BLOCK_BYTES = CARD_BLOCK_BYTES
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [1:0]               C_REQ,
  input  logic [1:0]               C_WE,
  input  logic [2*CARD_ADDR_W-1:0] C_ADDR,
  input  logic [1:0]               C_WD_STB,
  input  logic [15:0]              C_WD_DATA,
  output logic [1:0]               C_WD_ACK,
  output logic [1:0]               C_RES_STB,
  output logic [7:0]               C_RES_DATA,
  input  logic [1:0]               C_RES_ACK,
  output logic [1:0]               C_DONE,
  output logic                     BUSY,
  output logic                     WR_STB,
  output logic [CARD_ADDR_W-1:0]   WR_ADDR,
  input  logic                     WR_ACK,
  output logic                     RD_STB,
  output logic [CARD_ADDR_W-1:0]   RD_ADDR,
  input  logic                     RD_ACK,
  output logic                     WD_STB,
  output logic [7:0]               WD_DATA,
  input  logic                     WD_ACK,
  input  logic                     RES_STB,
  input  logic [7:0]               RES_DATA,
  output logic                     RES_ACK
);

  localparam int CNT_W = $clog2(BLOCK_BYTES) + 1;

  card_state_e            state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   we_q, we_d;
  logic [CARD_ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]       byteCnt_q, byteCnt_d;
  logic                   last_q, last_d;
  logic [1:0]             gnt;
  logic                   byteXfer;

  card_rr_pick uPick (
    .req  (C_REQ),
    .last (last_q),
    .gnt  (gnt)
  );

  // State register. 'last' comes out of reset as 1 so that a tie straight
  // after reset goes to client 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      byteCnt_q <= '0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      byteCnt_q <= byteCnt_d;
      last_q    <= last_d;
    end
  end

  // Next-state and output decode. Every stream output defaults to 0 and is
  // only connected to the owner's signals while in DATA, so strobes seen in
  // any other state (or from the non-owner) are never acknowledged. The
  // transaction ends on the transfer that brings the count to BLOCK_BYTES;
  // the owner dropping its request mid-block does not shorten it.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    byteCnt_d  = byteCnt_q;
    last_d     = last_q;
    byteXfer   = 1'b0;

    C_WD_ACK   = 2'b00;
    C_RES_STB  = 2'b00;
    C_RES_DATA = 8'h00;
    C_DONE     = 2'b00;
    BUSY       = (state_q != ST_IDLE);
    WR_STB     = 1'b0;
    WR_ADDR    = '0;
    RD_STB     = 1'b0;
    RD_ADDR    = '0;
    WD_STB     = 1'b0;
    WD_DATA    = 8'h00;
    RES_ACK    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|C_REQ) begin
          owner_d = gnt[1];
          we_d    = gnt[1] ? C_WE[1] : C_WE[0];
          addr_d  = gnt[1] ? C_ADDR[2*CARD_ADDR_W-1:CARD_ADDR_W]
                           : C_ADDR[CARD_ADDR_W-1:0];
          state_d = ST_CMD;
        end
      end

      ST_CMD: begin
        if (we_q) begin
          WR_STB  = 1'b1;
          WR_ADDR = addr_q;
        end else begin
          RD_STB  = 1'b1;
          RD_ADDR = addr_q;
        end
        if ((we_q && WR_ACK) || (!we_q && RD_ACK)) begin
          byteCnt_d = '0;
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (we_q) begin
          WD_STB            = C_WD_STB[owner_q];
          WD_DATA           = owner_q ? C_WD_DATA[15:8] : C_WD_DATA[7:0];
          C_WD_ACK[owner_q] = WD_ACK;
          byteXfer          = C_WD_STB[owner_q] && WD_ACK;
        end else begin
          C_RES_STB[owner_q] = RES_STB;
          C_RES_DATA         = RES_DATA;
          RES_ACK            = C_RES_ACK[owner_q];
          byteXfer           = RES_STB && C_RES_ACK[owner_q];
        end
        if (byteXfer) begin
          byteCnt_d = byteCnt_q + CNT_W'(1);
          if ((byteCnt_q + CNT_W'(1)) == CNT_W'(BLOCK_BYTES)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        C_DONE  = clientOneHot(owner_q);
        last_d  = owner_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_card_arbiter.sv
// ---------------------------------------------------------------------------
// tb_card_arbiter
// Self-checking bench for card_arbiter. A behavioural model plays both
// clients and the card_driver: it grants by the round-robin (or fixed
// priority) rule, tracks each block transaction from request to C_DONE and
// predicts every arbiter output cycle by cycle from the timing rules.
// Driver acks, read-data gaps and client back-pressure are randomised.
// ---------------------------------------------------------------------------
module tb_card_arbiter;
  import card_arbiter_pkg::*;

  localparam int NB = CARD_BLOCK_BYTES;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  C_REQ, C_WE, C_WD_STB, C_RES_ACK;
  logic [63:0] C_ADDR;
  logic [15:0] C_WD_DATA;
  logic [1:0]  C_WD_ACK, C_RES_STB, C_DONE;
  logic [7:0]  C_RES_DATA;
  logic        BUSY, WR_STB, RD_STB, WD_STB, RES_ACK;
  logic [31:0] WR_ADDR, RD_ADDR;
  logic        WR_ACK, RD_ACK, WD_ACK, RES_STB;
  logic [7:0]  WD_DATA, RES_DATA;

  card_arbiter dut (
    .CLK        (CLK),
    .RST        (RST),
    .C_REQ      (C_REQ),
    .C_WE       (C_WE),
    .C_ADDR     (C_ADDR),
    .C_WD_STB   (C_WD_STB),
    .C_WD_DATA  (C_WD_DATA),
    .C_WD_ACK   (C_WD_ACK),
    .C_RES_STB  (C_RES_STB),
    .C_RES_DATA (C_RES_DATA),
    .C_RES_ACK  (C_RES_ACK),
    .C_DONE     (C_DONE),
    .BUSY       (BUSY),
    .WR_STB     (WR_STB),
    .WR_ADDR    (WR_ADDR),
    .WR_ACK     (WR_ACK),
    .RD_STB     (RD_STB),
    .RD_ADDR    (RD_ADDR),
    .RD_ACK     (RD_ACK),
    .WD_STB     (WD_STB),
    .WD_DATA    (WD_DATA),
    .WD_ACK     (WD_ACK),
    .RES_STB    (RES_STB),
    .RES_DATA   (RES_DATA),
    .RES_ACK    (RES_ACK)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  int          tbLast;
  int          curW;
  bit          curWe;
  logic [31:0] curAddr;
  bit          cmdDone, dataActive, resPending;
  int          xferCnt, cyc, doneCyc;
  logic [7:0]  wrBytes [2][NB];
  logic [7:0]  rdBytes [NB];
  int          wIdx [2];
  bit          clientActive [2];
  bit          clientWe [2];
  logic [31:0] clientAddr [2];

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    checks++;
    assert (obs === expVal) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expVal);
    end
  endtask

  // Winner of the current request set under the arbitration rule.
  function automatic int pickWinner(input logic [1:0] req);
`ifdef CARD_ARB_FIXED_PRIO_EN
    return req[0] ? 0 : 1;
`else
    if (req == 2'b11) return (tbLast == 0) ? 1 : 0;
    return req[0] ? 0 : 1;
`endif
  endfunction

  task automatic setupClient(input int k, input bit we, input logic [31:0] addr, input bit counting);
    clientWe[k]   = we;
    clientAddr[k] = addr;
    for (int i = 0; i < NB; i++) begin
      wrBytes[k][i] = counting ? 8'(i) : 8'($urandom);
    end
  endtask

  task automatic raiseReq(input logic [1:0] mask);
    for (int k = 0; k < 2; k++) begin
      if (mask[k] && !clientActive[k]) begin
        clientActive[k] = 1'b1;
        wIdx[k]         = 0;
        C_REQ[k]        = 1'b1;
      end
    end
  endtask

  // Drive one cycle of driver and client behaviour. Clients hold their write
  // strobe until acked; the driver holds a read byte until acked and throws
  // spurious RES_STB pulses whenever it is not in a read data phase.
  task automatic applyStimulus();
    WR_ACK = 1'($urandom_range(0, 1));
    RD_ACK = 1'($urandom_range(0, 1));
    WD_ACK = ($urandom_range(0, 3) != 0);
    if (dataActive && !curWe) begin
      if (!resPending) resPending = ($urandom_range(0, 2) != 0);
      RES_STB  = resPending;
      RES_DATA = resPending ? rdBytes[xferCnt] : 8'($urandom);
    end else begin
      RES_STB  = 1'($urandom_range(0, 1));
      RES_DATA = 8'($urandom);
    end
    for (int k = 0; k < 2; k++) begin
      C_WE[k]              = clientWe[k];
      C_ADDR[32*k +: 32]   = clientAddr[k];
      C_WD_STB[k]          = clientActive[k] && clientWe[k] && (wIdx[k] < NB);
      C_WD_DATA[8*k +: 8]  = 8'h00;
      if (wIdx[k] < NB) C_WD_DATA[8*k +: 8] = wrBytes[k][wIdx[k]];
    end
    C_RES_ACK = 2'($urandom_range(0, 3));
  endtask

  // Compare every arbiter output against the model for this cycle, then
  // advance the model by whatever transfers happened on this cycle.
  task automatic checkOutput();
    logic [1:0] oh;
    bit         inCmd, nextData, xf;
    oh    = (curW == 1) ? 2'b10 : 2'b01;
    inCmd = (cyc >= 1) && !cmdDone;
    checkVal("BUSY", BUSY, (cyc >= 1));
    checkVal("WR_STB", WR_STB, inCmd && curWe);
    checkVal("RD_STB", RD_STB, inCmd && !curWe);
    if (inCmd && curWe)  checkVal("WR_ADDR", WR_ADDR, curAddr);
    if (inCmd && !curWe) checkVal("RD_ADDR", RD_ADDR, curAddr);
    if (dataActive && curWe) begin
      checkVal("WD_STB", WD_STB, (wIdx[curW] < NB));
      if (wIdx[curW] < NB) checkVal("WD_DATA", WD_DATA, wrBytes[curW][wIdx[curW]]);
      checkVal("C_WD_ACK", C_WD_ACK, WD_ACK ? oh : 2'b00);
    end else begin
      checkVal("WD_STB_masked", WD_STB, 0);
      checkVal("C_WD_ACK_masked", C_WD_ACK, 0);
    end
    if (dataActive && !curWe) begin
      checkVal("C_RES_STB", C_RES_STB, RES_STB ? oh : 2'b00);
      checkVal("RES_ACK", RES_ACK, C_RES_ACK[curW]);
      if (RES_STB && C_RES_ACK[curW]) checkVal("C_RES_DATA", C_RES_DATA, rdBytes[xferCnt]);
    end else begin
      checkVal("C_RES_STB_masked", C_RES_STB, 0);
      checkVal("RES_ACK_masked", RES_ACK, 0);
    end
    checkVal("C_DONE", C_DONE, (cyc == doneCyc) ? oh : 2'b00);

    nextData = dataActive;
    if (inCmd && (curWe ? WR_ACK : RD_ACK)) begin
      cmdDone  = 1'b1;
      nextData = 1'b1;
    end
    if (dataActive) begin
      xf = curWe ? (C_WD_STB[curW] && WD_ACK) : (RES_STB && C_RES_ACK[curW]);
      if (xf) begin
        xferCnt++;
        if (curWe) wIdx[curW]++;
        else resPending = 1'b0;
        if (xferCnt == NB) begin
          nextData = 1'b0;
          doneCyc  = cyc + 1;
        end
      end
    end
    dataActive = nextData;
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_ctrl"}, {BUSY, WR_STB, RD_STB, WD_STB, RES_ACK, C_DONE, C_WD_ACK, C_RES_STB}, 0);
    checkVal({tag, "_wr_addr"}, WR_ADDR, 0);
    checkVal({tag, "_rd_addr"}, RD_ADDR, 0);
    checkVal({tag, "_data"}, {WD_DATA, C_RES_DATA}, 0);
  endtask

  task automatic doReset();
    RST = 1'b1;
    C_REQ = 2'b00;
    clientActive[0] = 1'b0;
    clientActive[1] = 1'b0;
    dataActive = 1'b0;
    resPending = 1'b0;
    applyStimulus();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    tbLast = 1;
    checkAllZero("reset");
    @(posedge CLK);
    #1;
  endtask

  // Reset in the middle of a block: the very next cycle must show every
  // output at 0 and no completion pulse may follow.
  task automatic doAbort();
    RST = 1'b1;
    applyStimulus();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    checkAllZero("abort");
    C_REQ = 2'b00;
    clientActive[0] = 1'b0;
    clientActive[1] = 1'b0;
    dataActive = 1'b0;
    resPending = 1'b0;
    tbLast = 1;
    applyStimulus();
    #1;
    checkVal("abort_no_done", C_DONE, 0);
    checkVal("abort_idle", BUSY, 0);
    @(posedge CLK);
    #1;
  endtask

  // One whole transaction, starting on an idle cycle. addMask raises new
  // requests before the grant, lateMask raises more at cycle lateAt, the
  // owner drops its request after dropAt bytes, and abortAt resets the DUT
  // after that many bytes.
  task automatic serveOne(input logic [1:0] addMask, input logic [1:0] lateMask,
                          input int lateAt, input int dropAt, input int abortAt);
    int w;
    bit finished;
    raiseReq(addMask);
    w          = pickWinner(C_REQ);
    curW       = w;
    curWe      = clientWe[w];
    curAddr    = clientAddr[w];
    cmdDone    = 1'b0;
    dataActive = 1'b0;
    resPending = 1'b0;
    xferCnt    = 0;
    cyc        = 0;
    doneCyc    = -1;
    if (!curWe) begin
      for (int i = 0; i < NB; i++) rdBytes[i] = 8'($urandom);
    end
    $display("[TB] transaction: client %0d %s addr 0x%0h", w, curWe ? "write" : "read", curAddr);
    finished = 1'b0;
    for (int n = 0; n < 6000 && !finished; n++) begin
      if (abortAt > 0 && xferCnt == abortAt) begin
        doAbort();
        finished = 1'b1;
      end else begin
        if (lateMask != 2'b00 && cyc == lateAt) raiseReq(lateMask);
        if (dropAt > 0 && xferCnt == dropAt) C_REQ[w] = 1'b0;
        applyStimulus();
        #1;
        checkOutput();
        if (cyc == doneCyc) begin
          C_REQ[w]        = 1'b0;
          clientActive[w] = 1'b0;
          tbLast          = w;
          finished        = 1'b1;
        end
        cyc++;
        @(posedge CLK);
        #1;
      end
    end
    if (!finished) checkVal("txn_timeout", finished, 1);
  endtask

  // Watchdog against a hung simulation.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence of scenarios with randomised handshakes.
  initial begin
    wIdx[0] = 0;
    wIdx[1] = 0;
    clientWe[0] = 1'b0;
    clientWe[1] = 1'b0;
    clientAddr[0] = '0;
    clientAddr[1] = '0;
    setupClient(0, 1'b1, 32'h0, 1'b0);
    setupClient(1, 1'b1, 32'h0, 1'b0);
    doReset();

    C_REQ = 2'b00;
    C_WD_STB = 2'b11;
    RES_STB = 1'b1;
    WD_ACK = 1'b1;
    WR_ACK = 1'b1;
    RD_ACK = 1'b1;
    C_RES_ACK = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkVal("idle_wd_ack", C_WD_ACK, 0);
      checkVal("idle_res_ack", RES_ACK, 0);
      checkVal("idle_wd_stb", WD_STB, 0);
      checkVal("idle_busy", BUSY, 0);
      @(posedge CLK);
      #1;
    end

    setupClient(0, 1'b1, 32'h10, 1'b1);
    serveOne(2'b01, 2'b00, 0, 0, 0);
    setupClient(1, 1'b0, 32'h20, 1'b0);
    serveOne(2'b10, 2'b00, 0, 0, 0);

    doReset();
    setupClient(0, 1'b1, 32'h100, 1'b0);
    setupClient(1, 1'b0, 32'h200, 1'b0);
    serveOne(2'b11, 2'b00, 0, 0, 0);
    setupClient(0, 1'b1, 32'h104, 1'b0);
    serveOne(2'b01, 2'b00, 0, 0, 0);
    setupClient(0, 1'b0, 32'h108, 1'b0);
    serveOne(2'b01, 2'b00, 0, 0, 0);
    if (C_REQ != 2'b00) serveOne(2'b00, 2'b00, 0, 0, 0);

    setupClient(0, 1'b1, 32'h300, 1'b0);
    setupClient(1, 1'b1, 32'h400, 1'b0);
    serveOne(2'b01, 2'b10, 20, 50, 0);
    serveOne(2'b00, 2'b00, 0, 0, 0);

    setupClient(0, 1'b1, 32'h500, 1'b0);
    serveOne(2'b01, 2'b00, 0, 0, 100);
    setupClient(1, 1'b0, 32'h600, 1'b0);
    serveOne(2'b10, 2'b00, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
